mux_scan_sampler: RTL
=====================

Name: mux_scan_sampler

Overview:
- Sequential front-end that drives the select of a 4-to-1, 4-bit data mux and captures its output.
- Scans the enabled input channels in round-robin order.
- Waits a programmable settle time after each select change, then registers the selected data.
- Presents each sample downstream with a valid/ready handshake, tagged with its channel number.

Parameters:
- SETTLE_CYCLES, default 1: cycles sel is held before capture; legal range 1..15.
- CNT_W, default 8: width of the sample counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin scanning; honoured only in IDLE
- stop  in  1  request to end scanning after the current capture
- en_mask  in  4  per-channel enable, bit i = channel i
- d0, d1, d2, d3  in  4 each  channel data, routed into the internal mux
- sel  out  2  current mux select (registered), exported for debug
- out_data  out  4  captured sample
- out_ch  out  2  channel the sample came from
- out_valid  out  1  sample available
- out_ready  in  1  downstream accepts the sample when out_valid && out_ready
- busy  out  1  high in any state other than IDLE
- sample_cnt  out  CNT_W  number of captures since the last start

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; sel, out_data, out_ch, out_valid, busy, sample_cnt, settle counter and stop flag all 0.
- States and transitions:
  - IDLE: on start && en_mask != 0 → SETTLE. Sets sel = lowest enabled channel, clears sample_cnt, loads settle counter. start with en_mask == 0 is ignored.
  - SETTLE: counter decrements each cycle; after SETTLE_CYCLES cycles in SETTLE → CAPTURE.
  - CAPTURE: captures if the output slot is free (!out_valid || out_ready in the same cycle); otherwise stalls in CAPTURE with sel held.
- On capture:
  - out_data ← mux output, out_ch ← sel, out_valid ← 1.
  - sample_cnt increments, wrapping from max to 0.
  - If stop flag set or en_mask == 0: → IDLE, sel unchanged.
  - Otherwise sel ← next enabled channel, searched in order sel+1, sel+2, sel+3, sel (mod 4); reload counter; → SETTLE.
- Stop flag:
  - Set by stop while busy; cleared on entry to IDLE.
  - stop in IDLE is ignored.
  - stop and start in the same IDLE cycle: start wins, stop is ignored.
- en_mask is sampled only when choosing a channel (on start and on capture). Changes during SETTLE do not disturb the current channel.
- Output slot:
  - out_valid stays high, with out_data/out_ch stable, until out_valid && out_ready.
  - Handshake and a new capture in the same cycle: the new sample replaces the old one and out_valid stays 1. No bubble.
  - Handshake with no capture that cycle: out_valid → 0.
- Timing:
  - Start sampled at edge A: first out_valid at edge A+1+SETTLE_CYCLES.
  - With no backpressure, one sample every SETTLE_CYCLES+1 cycles.
- The slot is not flushed on return to IDLE; a pending sample is still delivered.
- rst_n low mid-scan: the pending sample is discarded and everything returns to reset values on that edge.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum typedef (IDLE, SETTLE, CAPTURE)
  - NUM_CH = 4, DATA_W = 4, CH_W = 2
  - function next_enabled(cur, mask) returning the round-robin successor
- One sub-module: the existing 4-bit 4-to-1 mux_4_1, instanced once. Its sel input is the registered sel; its y output is the capture source.
- FSM, settle counter, output slot and sample counter live in the top module.

Test Plan:
- Full mask, out_ready=1, d0..d3 = 4'h1, 4'h2, 4'h3, 4'h4, SETTLE_CYCLES=1, start pulse → out_data sequence 1, 2, 3, 4, 1…, out_ch 0, 1, 2, 3, 0…; first out_valid 2 edges after the start edge, one sample every 2 cycles.
- en_mask=4'b1010 → out_ch alternates 1, 3, 1, 3. Switch en_mask to 4'b0100 mid-SETTLE → current channel completes, then only channel 2 is sampled.
- out_ready=0 for 5 cycles after the first sample → out_valid held, out_data stable, FSM stalls in CAPTURE, sample_cnt stays 1. Release out_ready → next sample accepted the same cycle, no bubble.
- stop asserted mid-SETTLE → exactly one more capture, then busy=0, sel unchanged. start with en_mask=0 → no change.
- rst_n=0 during CAPTURE with out_valid=1 → next edge: out_valid=0, sel=0, sample_cnt=0, busy=0.
- CNT_W=2: 5 captures → sample_cnt reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/mux_scan_sampler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types, sizes and the round-robin channel search used
//               by the mux scan sampler.
//               Contents: state_t (IDLE/SETTLE/CAPTURE), NUM_CH, DATA_W, CH_W,
//               next_enabled(cur, mask).
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 4;
  localparam int CH_W   = 2;

  // Index of the last channel; searching "after" it yields the lowest one.
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // Round-robin successor: first enabled channel in the order
  // cur+1, cur+2, cur+3, cur (all mod NUM_CH). Returns cur when mask is 0.
  function automatic logic [CH_W-1:0] next_enabled(
    input logic [CH_W-1:0]   cur,
    input logic [NUM_CH-1:0] mask
  );
    logic [CH_W-1:0] idx;
    logic            found;
    next_enabled = cur;
    found        = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur + CH_W'(i);
      if (!found && mask[idx]) begin
        next_enabled = idx;
        found        = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_sampler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_scan_sampler_if
// Description : Control, channel-data and sample-output bundle of the mux
//               scan sampler.
//               master : scan controller user (drives start/stop/en_mask,
//                        channel data and out_ready)
//               slave  : the sampler itself
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_sampler_if
  import mux_scan_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic              start;
  logic              stop;
  logic [NUM_CH-1:0] en_mask;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic [DATA_W-1:0] d2;
  logic [DATA_W-1:0] d3;
  logic [CH_W-1:0]   sel;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  sample_cnt;

  modport master (
    output start, stop, en_mask, d0, d1, d2, d3, out_ready,
    input  sel, out_data, out_ch, out_valid, busy, sample_cnt
  );

  modport slave (
    input  start, stop, en_mask, d0, d1, d2, d3, out_ready,
    output sel, out_data, out_ch, out_valid, busy, sample_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mux_scan_sampler_mux_4_1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_4_1
// Description : 4-to-1 data multiplexer, DATA_W bits wide.
//               d0..d3 : channel inputs
//               sel    : channel select
//               y      : selected channel
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_1
  import mux_scan_pkg::*;
(
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  input  logic [CH_W-1:0]   sel,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux_scan_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mux_scan_sampler
// Description : Round-robin scanner for a 4-to-1 data mux. Drives the mux
//               select, waits SETTLE_CYCLES after every select change, then
//               captures the mux output into a one-entry valid/ready slot
//               tagged with its channel number.
//               clk   : rising-edge clock
//               rst_n : synchronous active-low reset
//               bus   : control, channel data and sample output (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,   // 1..15
  parameter int CNT_W         = 8
)
(
  input  logic                clk,
  input  logic                rst_n,
  mux_scan_sampler_if.slave   bus
);

  localparam logic [3:0] C_SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_W-1:0]    r_sel;
  logic [3:0]         r_settle_cnt;
  logic               r_stop;
  logic [DATA_W-1:0]  r_out_data;
  logic [CH_W-1:0]    r_out_ch;
  logic               r_out_valid;
  logic [CNT_W-1:0]   r_sample_cnt;

  logic [DATA_W-1:0]  w_mux_y;
  logic               w_slot_free;
  logic               w_launch;
  logic               w_capture;
  logic               w_end_scan;
  logic               w_busy;

  mux_4_1 u_mux (
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .sel (r_sel),
    .y   (w_mux_y)
  );

  // A capture may overwrite the slot when it is empty or being drained now.
  assign w_slot_free = !r_out_valid || bus.out_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle_cnt <= 4'd1) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (w_capture) w_state_nxt = w_end_scan ? ST_IDLE : ST_SETTLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_launch   = (r_state == ST_IDLE) && bus.start && (bus.en_mask != '0);
    w_capture  = (r_state == ST_CAPTURE) && w_slot_free;
    w_end_scan = w_capture && (r_stop || (bus.en_mask == '0));
  end

  // ------------------------------------------- select, settle, stop, count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel        <= '0;
      r_settle_cnt <= '0;
      r_stop       <= 1'b0;
      r_sample_cnt <= '0;
    end else begin
      if (w_launch) begin
        r_sel        <= next_enabled(LAST_CH, bus.en_mask);
        r_settle_cnt <= C_SETTLE_LOAD;
        r_sample_cnt <= '0;
      end else if (r_state == ST_SETTLE) begin
        r_settle_cnt <= r_settle_cnt - 4'd1;
      end else if (w_capture) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        // On the final capture sel is left pointing at the last channel.
        if (!w_end_scan) begin
          r_sel        <= next_enabled(r_sel, bus.en_mask);
          r_settle_cnt <= C_SETTLE_LOAD;
        end
      end

      // Leaving for IDLE clears the request; start in IDLE never sets it.
      if (w_end_scan) begin
        r_stop <= 1'b0;
      end else if (w_busy && bus.stop) begin
        r_stop <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ out slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_data  <= w_mux_y;
      r_out_ch    <= r_sel;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.sel        = r_sel;
  assign bus.out_data   = r_out_data;
  assign bus.out_ch     = r_out_ch;
  assign bus.out_valid  = r_out_valid;
  assign bus.busy       = w_busy;
  assign bus.sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire
